// File: rtl/demoman_pkg.sv
// Shared constants for the bounce painter: default VGA geometry, RGB332 colours
// and the 8-entry bounce palette.
package demoman_pkg;

    localparam int unsigned H_ACTIVE_DEFAULT = 640;
    localparam int unsigned V_ACTIVE_DEFAULT = 480;

    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] WHITE = 8'hFF;
    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] GREEN = 8'h1C;
    localparam logic [7:0] BLUE  = 8'h03;

    localparam int unsigned PALETTE_SIZE = 8;

    // Direction of travel along one axis; INC moves right (x) or down (y).
    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    function automatic logic [7:0] palette_color(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = RED;
            3'd1:    c = 8'hFC;
            3'd2:    c = GREEN;
            3'd3:    c = 8'h1F;
            3'd4:    c = BLUE;
            3'd5:    c = 8'hE3;
            3'd6:    c = 8'h92;
            default: c = WHITE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bounce_painter_if.sv
// Pixel bus between vga_driver and the painter: coordinates out, colour back.
// Free-running stream, one pixel per clock, no valid/ready: next_x/next_y are
// always meaningful and color_out is their colour one clock later.
interface bounce_painter_if;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic [7:0] color_out;

    modport master (output next_x, output next_y, input color_out);
    modport slave  (input next_x, input next_y, output color_out);
endinterface

// File: rtl/bounce_axis.sv
// One axis of the bouncing rectangle: position register plus travel direction,
// clamped to [0, LIM] and reversed on contact with either end.
module bounce_axis
    import demoman_pkg::*;
#(
    parameter int unsigned LIM   = 608,
    parameter int unsigned SPEED = 2,
    parameter int unsigned INIT  = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       step,
    output logic [9:0] pos,
    output logic       flip
);

    dir_t        dir_q;
    dir_t        dir_d;
    logic [9:0]  pos_d;
    logic [10:0] pos_w;
    logic [10:0] fwd_sum;

    // 11-bit arithmetic so pos+SPEED never wraps before the limit compare.
    assign pos_w   = {1'b0, pos};
    assign fwd_sum = pos_w + 11'(SPEED);

    always_comb begin
        pos_d = pos;
        dir_d = dir_q;
        flip  = 1'b0;
        if (step) begin
            if (dir_q == DIR_INC) begin
                if (fwd_sum >= 11'(LIM)) begin
                    pos_d = 10'(LIM);
                    dir_d = DIR_DEC;
                    flip  = 1'b1;
                end else begin
                    pos_d = fwd_sum[9:0];
                end
            end else begin
                if (pos_w <= 11'(SPEED)) begin
                    pos_d = '0;
                    dir_d = DIR_INC;
                    flip  = 1'b1;
                end else begin
                    pos_d = pos - 10'(SPEED);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pos   <= 10'(INIT);
            dir_q <= DIR_INC;
        end else begin
            pos   <= pos_d;
            dir_q <= dir_d;
        end
    end

endmodule

// File: rtl/bounce_painter.sv
// Colour generator for vga_driver: a solid rectangle that moves once per frame,
// bounces off the active-area edges and changes palette colour on each bounce.
module bounce_painter
    import demoman_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int unsigned BOX_W    = 32,
    parameter int unsigned BOX_H    = 32,
    parameter int unsigned SPEED    = 2,
    parameter int unsigned INIT_X   = 0,
    parameter int unsigned INIT_Y   = 0,
    parameter logic [7:0]  BG_COLOR = WHITE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    bounce_painter_if.slave   pix,
    output logic              frame_tick,
    output logic [9:0]        box_x,
    output logic [9:0]        box_y,
    output logic [15:0]       frame_count
);

    logic [9:0]  prev_y;
    logic [2:0]  idx;
    logic        frame_event;
    logic        step;
    logic        flip_x;
    logic        flip_y;

    logic [10:0] nx;
    logic [10:0] ny;
    logic [10:0] bx;
    logic [10:0] by;
    logic        in_active;
    logic        in_box;
    logic [7:0]  pixel_color;

    // The 479->480 transition only happens once per frame and lands in
    // vertical blanking, so moving the box here never tears the picture.
    assign frame_event = (prev_y == 10'(V_ACTIVE - 1)) && (pix.next_y == 10'(V_ACTIVE));
    assign step        = frame_event && enable;

    bounce_axis #(
        .LIM   (H_ACTIVE - BOX_W),
        .SPEED (SPEED),
        .INIT  (INIT_X)
    ) u_axis_x (
        .clock (clock),
        .reset (reset),
        .step  (step),
        .pos   (box_x),
        .flip  (flip_x)
    );

    bounce_axis #(
        .LIM   (V_ACTIVE - BOX_H),
        .SPEED (SPEED),
        .INIT  (INIT_Y)
    ) u_axis_y (
        .clock (clock),
        .reset (reset),
        .step  (step),
        .pos   (box_y),
        .flip  (flip_y)
    );

    always_comb begin
        nx        = {1'b0, pix.next_x};
        ny        = {1'b0, pix.next_y};
        bx        = {1'b0, box_x};
        by        = {1'b0, box_y};
        in_active = (nx < 11'(H_ACTIVE)) && (ny < 11'(V_ACTIVE));
        in_box    = (nx >= bx) && (nx <= bx + 11'(BOX_W - 1)) &&
                    (ny >= by) && (ny <= by + 11'(BOX_H - 1));
        if (!in_active) begin
            pixel_color = BLACK;
        end else if (in_box) begin
            pixel_color = palette_color(idx);
        end else begin
            pixel_color = BG_COLOR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_y        <= '0;
            frame_tick    <= 1'b0;
            frame_count   <= '0;
            idx           <= '0;
            pix.color_out <= BLACK;
        end else begin
            prev_y        <= pix.next_y;
            frame_tick    <= frame_event;
            pix.color_out <= pixel_color;
            if (frame_event) begin
                frame_count <= frame_count + 16'd1;
            end
            // A corner hit flips both axes but still advances the colour once.
            if (flip_x || flip_y) begin
                idx <= idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_bounce_painter.sv
// Directed bench for bounce_painter: pixel vector table plus frame sequences on
// three instances (default, right-wall start, corner start).
module tb_bounce_painter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [9:0]  nx = '0;
    logic [9:0]  ny = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- clock / reset ----------------
    always #20 clock = ~clock;

    bounce_painter_if m_if ();
    bounce_painter_if r_if ();
    bounce_painter_if c_if ();

    assign m_if.next_x = nx;
    assign m_if.next_y = ny;
    assign r_if.next_x = nx;
    assign r_if.next_y = ny;
    assign c_if.next_x = nx;
    assign c_if.next_y = ny;

    logic        m_tick, r_tick, c_tick;
    logic [9:0]  m_bx, m_by, r_bx, r_by, c_bx, c_by;
    logic [15:0] m_cnt, r_cnt, c_cnt;

    bounce_painter dut (
        .clock (clock), .reset (reset), .enable (enable), .pix (m_if),
        .frame_tick (m_tick), .box_x (m_bx), .box_y (m_by), .frame_count (m_cnt)
    );

    bounce_painter #(.INIT_X(604), .INIT_Y(100)) dut_r (
        .clock (clock), .reset (reset), .enable (enable), .pix (r_if),
        .frame_tick (r_tick), .box_x (r_bx), .box_y (r_by), .frame_count (r_cnt)
    );

    bounce_painter #(.INIT_X(608), .INIT_Y(448)) dut_c (
        .clock (clock), .reset (reset), .enable (enable), .pix (c_if),
        .frame_tick (c_tick), .box_x (c_bx), .box_y (c_by), .frame_count (c_cnt)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic pixel(input logic [9:0] x, input logic [9:0] y);
        nx = x;
        ny = y;
        @(posedge clock);
        #1;
    endtask

    // Present 479 then 480: the frame event edge is the second clock.
    task automatic run_frame(input string name);
        pixel(nx, 10'd479);
        check({name, "_pre_tick"}, 32'(m_tick), 32'd0);
        pixel(nx, 10'd480);
        check({name, "_tick"}, 32'(m_tick), 32'd1);
    endtask

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] exp;
    } pix_vec_t;

    pix_vec_t vecs[10];

    initial begin
        // Box at (0,0)-(31,31), palette index 0 = E0, background FF.
        vecs[0] = '{10'd0,    10'd0,    8'hE0};
        vecs[1] = '{10'd10,   10'd10,   8'hE0};
        vecs[2] = '{10'd31,   10'd31,   8'hE0};
        vecs[3] = '{10'd32,   10'd31,   8'hFF};
        vecs[4] = '{10'd31,   10'd32,   8'hFF};
        vecs[5] = '{10'd40,   10'd10,   8'hFF};
        vecs[6] = '{10'd639,  10'd479,  8'hFF};
        vecs[7] = '{10'd640,  10'd0,    8'h00};
        vecs[8] = '{10'd0,    10'd500,  8'h00};
        vecs[9] = '{10'd1023, 10'd1023, 8'h00};

        repeat (2) @(posedge clock);
        #1;
        check("rst_color", 32'(m_if.color_out), 32'h00);
        check("rst_tick", 32'(m_tick), 32'd0);
        check("rst_count", 32'(m_cnt), 32'd0);
        check("rst_box_x", 32'(m_bx), 32'd0);
        check("rst_box_y", 32'(m_by), 32'd0);
        check("rst_r_box_x", 32'(r_bx), 32'd604);
        check("rst_c_box_y", 32'(c_by), 32'd448);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            pixel(vecs[i].x, vecs[i].y);
            check($sformatf("vec%0d_color", i), 32'(m_if.color_out), 32'(vecs[i].exp));
        end
        pixel(10'd604, 10'd100);
        check("r_edge_in", 32'(r_if.color_out), 32'hE0);
        pixel(10'd603, 10'd100);
        check("r_edge_out", 32'(r_if.color_out), 32'hFF);

        // Frame 1
        run_frame("f1");
        check("f1_box_x", 32'(m_bx), 32'd2);
        check("f1_box_y", 32'(m_by), 32'd2);
        check("f1_count", 32'(m_cnt), 32'd1);
        check("f1_r_box_x", 32'(r_bx), 32'd606);
        check("f1_c_box_x", 32'(c_bx), 32'd608);
        check("f1_c_box_y", 32'(c_by), 32'd448);
        pixel(nx, 10'd480);
        check("f1_hold_no_tick", 32'(m_tick), 32'd0);
        check("f1_hold_count", 32'(m_cnt), 32'd1);

        // Frame 2: right instance hits the wall, corner instance leaves the corner
        run_frame("f2");
        check("f2_count", 32'(m_cnt), 32'd2);
        check("f2_r_box_x", 32'(r_bx), 32'd608);
        check("f2_r_box_y", 32'(r_by), 32'd104);
        check("f2_c_box_x", 32'(c_bx), 32'd606);
        check("f2_c_box_y", 32'(c_by), 32'd446);
        pixel(10'd610, 10'd110);
        check("f2_r_color", 32'(r_if.color_out), 32'hFC);
        check("f2_c_bg", 32'(c_if.color_out), 32'hFF);
        pixel(10'd610, 10'd450);
        check("f2_c_color", 32'(c_if.color_out), 32'hFC);
        check("f2_r_bg", 32'(r_if.color_out), 32'hFF);

        // Frame 3
        run_frame("f3");
        check("f3_r_box_x", 32'(r_bx), 32'd606);
        check("f3_box_x", 32'(m_bx), 32'd6);
        pixel(10'd610, 10'd110);
        check("f3_r_color", 32'(r_if.color_out), 32'hFC);

        // Frozen motion
        enable = 1'b0;
        for (int f = 0; f < 5; f++) begin
            run_frame($sformatf("frz%0d", f));
        end
        check("frz_box_x", 32'(m_bx), 32'd6);
        check("frz_box_y", 32'(m_by), 32'd6);
        check("frz_count", 32'(m_cnt), 32'd8);
        check("frz_r_box_x", 32'(r_bx), 32'd606);
        pixel(10'd640, 10'd10);
        check("frz_blank_x", 32'(m_if.color_out), 32'h00);
        pixel(10'd10, 10'd500);
        check("frz_blank_y", 32'(m_if.color_out), 32'h00);
        enable = 1'b1;

        // Reset at next_y=479, then 480 with no post-reset 479 sample
        nx = 10'd0;
        ny = 10'd479;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_color", 32'(m_if.color_out), 32'h00);
        reset = 1'b0;
        pixel(10'd0, 10'd480);
        check("mid_rst_no_tick", 32'(m_tick), 32'd0);
        check("mid_rst_count", 32'(m_cnt), 32'd0);
        check("mid_rst_box_x", 32'(m_bx), 32'd0);
        check("mid_rst_box_y", 32'(m_by), 32'd0);
        check("mid_rst_c_box_x", 32'(c_bx), 32'd608);
        pixel(10'd608, 10'd448);
        check("mid_rst_c_idx", 32'(c_if.color_out), 32'hE0);

        run_frame("post_rst");
        check("post_rst_count", 32'(m_cnt), 32'd1);
        check("post_rst_box_x", 32'(m_bx), 32'd2);
        check("post_rst_box_y", 32'(m_by), 32'd2);
        check("post_rst_c_box_x", 32'(c_bx), 32'd608);
        check("post_rst_c_box_y", 32'(c_by), 32'd448);
        pixel(10'd608, 10'd448);
        check("post_rst_c_color", 32'(c_if.color_out), 32'hFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
